// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator driven by the code-DDS phase MSB.
// Produces early/prompt/late chips at half-chip spacing, chip index and epoch pulse.
module ca_code_gen #(
    parameter int PHASE_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PHASE_WIDTH-1:0] phase,
    input  logic [5:0]             prn,
    input  logic                   init,
    output logic                   early,
    output logic                   prompt,
    output logic                   late,
    output logic [9:0]             chip_idx,
    output logic                   epoch
);

    logic [10:1] r_g1;
    logic [10:1] r_g2;
    logic [5:0]  r_prn_q;
    logic        r_first;
    logic        r_msb_q;
    logic [1:0]  r_sr;
    logic [9:0]  r_chip_idx;
    logic        r_epoch;

    logic        w_msb;
    logic        w_fall;
    logic        w_rise;
    logic        w_wrap;
    logic        w_valid;
    logic [10:1] w_sel;
    logic        w_early;
    logic        w_unused;

    assign w_msb    = phase[PHASE_WIDTH-1];
    assign w_unused = ^phase;
    assign w_fall   = r_msb_q & ~w_msb;
    assign w_rise   = ~r_msb_q & w_msb;
    assign w_wrap   = w_fall && (r_chip_idx == 10'd1022);

    function automatic logic [9:0] taps(input int a, input int b);
        return (10'd1 << (a - 1)) | (10'd1 << (b - 1));
    endfunction

    // G2 phase-selector taps; XOR of the two selected stages is a masked reduction
    always_comb begin
        w_sel = '0;
        case (r_prn_q)
            6'd1:  w_sel = taps(2, 6);
            6'd2:  w_sel = taps(3, 7);
            6'd3:  w_sel = taps(4, 8);
            6'd4:  w_sel = taps(5, 9);
            6'd5:  w_sel = taps(1, 9);
            6'd6:  w_sel = taps(2, 10);
            6'd7:  w_sel = taps(1, 8);
            6'd8:  w_sel = taps(2, 9);
            6'd9:  w_sel = taps(3, 10);
            6'd10: w_sel = taps(2, 3);
            6'd11: w_sel = taps(3, 4);
            6'd12: w_sel = taps(5, 6);
            6'd13: w_sel = taps(6, 7);
            6'd14: w_sel = taps(7, 8);
            6'd15: w_sel = taps(8, 9);
            6'd16: w_sel = taps(9, 10);
            6'd17: w_sel = taps(1, 4);
            6'd18: w_sel = taps(2, 5);
            6'd19: w_sel = taps(3, 6);
            6'd20: w_sel = taps(4, 7);
            6'd21: w_sel = taps(5, 8);
            6'd22: w_sel = taps(6, 9);
            6'd23: w_sel = taps(1, 3);
            6'd24: w_sel = taps(4, 6);
            6'd25: w_sel = taps(5, 7);
            6'd26: w_sel = taps(6, 8);
            6'd27: w_sel = taps(7, 9);
            6'd28: w_sel = taps(8, 10);
            6'd29: w_sel = taps(1, 6);
            6'd30: w_sel = taps(2, 7);
            6'd31: w_sel = taps(3, 8);
            6'd32: w_sel = taps(4, 9);
            default: w_sel = '0;
        endcase
    end

    assign w_valid = (r_prn_q != 6'd0) && (r_prn_q <= 6'd32);
    assign w_early = w_valid & (r_g1[10] ^ (^(r_g2 & w_sel)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_g1       <= 10'h3FF;
            r_g2       <= 10'h3FF;
            r_first    <= 1'b1;
            r_msb_q    <= 1'b0;
            r_sr       <= 2'b00;
            r_chip_idx <= 10'd0;
            r_epoch    <= 1'b0;
        end else if (init) begin
            r_g1       <= 10'h3FF;
            r_g2       <= 10'h3FF;
            r_first    <= 1'b0;
            r_msb_q    <= w_msb;
            r_sr       <= 2'b00;
            r_chip_idx <= 10'd0;
            r_epoch    <= 1'b0;
        end else begin
            r_first <= 1'b0;
            r_msb_q <= w_msb;
            r_epoch <= w_wrap;
            if (w_fall || w_rise)
                r_sr <= {r_sr[0], w_early};
            if (w_wrap) begin
                r_g1       <= 10'h3FF;
                r_g2       <= 10'h3FF;
                r_chip_idx <= 10'd0;
            end else if (w_fall) begin
                r_g1       <= {r_g1[9:1], r_g1[3] ^ r_g1[10]};
                r_g2       <= {r_g2[9:1], r_g2[2] ^ r_g2[3] ^ r_g2[6] ^ r_g2[8] ^ r_g2[9] ^ r_g2[10]};
                r_chip_idx <= r_chip_idx + 10'd1;
            end
        end
    end

    // PRN is captured on the first edge after reset release and on init; no reset value
    always_ff @(posedge clk) begin
        if (r_first || init)
            r_prn_q <= prn;
    end

    assign early    = w_early;
    assign prompt   = w_valid & r_sr[0];
    assign late     = w_valid & r_sr[1];
    assign chip_idx = r_chip_idx;
    assign epoch    = r_epoch;

endmodule

// File: tb/tb_ca_code_gen.sv
// Bench for ca_code_gen: Gold codes built from polynomial recurrences over
// bit arrays, half-chip history kept as a sample queue, checked every clock.
module tb_ca_code_gen;

    localparam int PW = 3;

    logic          clk;
    logic          reset_n;
    logic [PW-1:0] phase;
    logic [5:0]    prn;
    logic          init;
    logic          early;
    logic          prompt;
    logic          late;
    logic [9:0]    chip_idx;
    logic          epoch;

    ca_code_gen #(.PHASE_WIDTH(PW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .phase    (phase),
        .prn      (prn),
        .init     (init),
        .early    (early),
        .prompt   (prompt),
        .late     (late),
        .chip_idx (chip_idx),
        .epoch    (epoch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ep_cnt = 0;

    // reference code table and model state
    bit   code_tab [0:32][0:1022];
    int   tap_a [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int   tap_b [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    int   m_prn;
    int   m_idx;
    bit   m_epoch;
    bit   m_msb;
    bit   m_first;
    logic hist[$];

    task automatic build_tables();
        bit s [0:1032];
        bit u [0:1032];
        for (int j = 0; j < 10; j++) begin
            s[j] = 1'b1;
            u[j] = 1'b1;
        end
        for (int j = 10; j <= 1032; j++) begin
            s[j] = s[j-3] ^ s[j-10];
            u[j] = u[j-2] ^ u[j-3] ^ u[j-6] ^ u[j-8] ^ u[j-9] ^ u[j-10];
        end
        for (int p = 1; p <= 32; p++)
            for (int t = 0; t < 1023; t++)
                code_tab[p][t] = s[t] ^ u[t + 10 - tap_a[p]] ^ u[t + 10 - tap_b[p]];
    endtask

    function automatic logic exp_early(input int p, input int idx);
        if (p < 1 || p > 32) return 1'b0;
        return code_tab[p][idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("early",    early,    exp_early(m_prn, m_idx));
        chk("prompt",   prompt,   hist[1]);
        chk("late",     late,     hist[0]);
        chk("chip_idx", chip_idx, m_idx);
        chk("epoch",    epoch,    m_epoch);
        if (epoch === 1'b1) ep_cnt++;
    endtask

    task automatic model_clear();
        m_idx   = 0;
        m_epoch = 1'b0;
        hist    = '{1'b0, 1'b0};
    endtask

    // one clock: drive at negedge, advance model after posedge, check at next negedge
    task automatic step(input logic msb, input logic do_init);
        logic [PW-1:0] p;
        logic          e;
        bit            fall, rise;
        p        = PW'($urandom);
        p[PW-1]  = msb;
        phase    = p;
        init     = do_init;
        @(posedge clk);
        fall = m_msb & ~msb;
        rise = ~m_msb & msb;
        if (do_init) begin
            model_clear();
            m_prn = prn;
        end else begin
            e = exp_early(m_prn, m_idx);
            if (m_first) m_prn = prn;
            if (fall || rise) begin
                hist.push_back(e);
                void'(hist.pop_front());
            end
            m_epoch = fall && (m_idx == 1022);
            if (fall) m_idx = (m_idx + 1) % 1023;
        end
        m_first = 1'b0;
        m_msb   = msb;
        @(negedge clk);
        init = 1'b0;
        check_all();
    endtask

    // one full chip: second half (MSB high) then fall into the next chip
    task automatic tick(input int h);
        repeat (h) step(1'b1, 1'b0);
        repeat (h) step(1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_early",  early,    (m_prn >= 1 && m_prn <= 32) ? 1 : 0);
        chk("rst_prompt", prompt,   0);
        chk("rst_late",   late,     0);
        chk("rst_idx",    chip_idx, 0);
        chk("rst_epoch",  epoch,    0);
        model_clear();
        m_msb   = 1'b0;
        m_first = 1'b1;
        phase   = '0;
        repeat (2) @(posedge clk);
        m_prn = prn;
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
    endtask

    logic [9:0] rec;

    initial begin
        build_tables();
        reset_n = 1'b0;
        phase   = '0;
        prn     = 6'd1;
        init    = 1'b0;
        model_clear();
        m_msb   = 1'b0;
        m_first = 1'b1;
        repeat (3) @(posedge clk);
        m_prn = prn;
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        repeat (2) step(1'b0, 1'b0);

        // PRN1 first ten chips after reset release
        rec = '0;
        for (int i = 0; i < 10; i++) begin
            rec = {rec[8:0], early};
            tick(2);
        end
        chk("prn1_seq", rec, 10'o1440);
        chk("prn1_idx10", chip_idx, 10);

        // PRN2 after init
        prn = 6'd2;
        step(1'b0, 1'b1);
        rec = '0;
        for (int i = 0; i < 10; i++) begin
            rec = {rec[8:0], early};
            tick(3);
        end
        chk("prn2_seq", rec, 10'o1620);

        // PRN1 full periods at 8 clk/chip
        prn = 6'd1;
        step(1'b0, 1'b1);
        ep_cnt = 0;
        repeat (1023) tick(4);
        chk("epoch_cnt1", ep_cnt, 1);
        chk("wrap_idx", chip_idx, 0);
        rec = '0;
        for (int i = 0; i < 10; i++) begin
            rec = {rec[8:0], early};
            tick(4);
        end
        chk("prn1_repeat", rec, 10'o1440);
        repeat (1013) tick(4);
        chk("epoch_cnt2", ep_cnt, 2);

        // PRN5 full period, MSB toggling every 4 clk
        prn = 6'd5;
        step(1'b0, 1'b1);
        repeat (1023) tick(4);

        // prn change without init is ignored; init coincident with the 1022 fall
        prn = 6'd9;
        repeat (1022) tick(1);
        chk("pre_init_idx", chip_idx, 1022);
        ep_cnt = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("init_idx", chip_idx, 0);
        chk("init_early", early, 1);
        repeat (3) step(1'b0, 1'b0);
        chk("init_no_epoch", ep_cnt, 0);
        repeat (10) tick(2);

        // randomized PRNs and chip rates
        for (int r = 0; r < 3; r++) begin
            prn = 6'($urandom_range(1, 32));
            step(1'b0, 1'b1);
            for (int i = 0; i < 150; i++) tick($urandom_range(1, 4));
        end

        // out-of-range PRNs keep outputs low while counting
        prn = 6'd0;
        async_reset();
        repeat (20) tick($urandom_range(1, 3));
        chk("prn0_idx", chip_idx, 20);
        prn = 6'd40;
        step(1'b0, 1'b1);
        repeat (20) tick($urandom_range(1, 3));
        chk("prn40_idx", chip_idx, 20);

        // asynchronous reset in the middle of a chip
        prn = 6'd3;
        step(1'b0, 1'b1);
        repeat (5) tick(2);
        repeat (2) step(1'b1, 1'b0);
        async_reset();
        repeat (10) tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
